// File: rtl/alu_pkg.sv
// alu_pkg
// Shared ALU definitions used by the ALU, its downstream result buffer and
// their benches.
//   ALU_LENGTH  default ALU operand width
//   ALU_RES_W   result word width (twice the operand width)
//   alu_flags_t status flags that travel alongside every result word
//   alu_op_e    ALU control codes
package alu_pkg;

  localparam int ALU_LENGTH = 5;
  localparam int ALU_RES_W  = 2 * ALU_LENGTH;

  // The field order fixes how the flags pack below the result in a stored entry.
  typedef struct packed {
    logic overflow;
    logic negative;
    logic zero;
  } alu_flags_t;

  localparam int ALU_FLAGS_W = $bits(alu_flags_t);

  typedef enum logic [2:0] {
    ALU_OP_ADD = 3'd0,
    ALU_OP_SUB = 3'd1,
    ALU_OP_MUL = 3'd2,
    ALU_OP_AND = 3'd3,
    ALU_OP_OR  = 3'd4,
    ALU_OP_XOR = 3'd5,
    ALU_OP_SHL = 3'd6,
    ALU_OP_SHR = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_fifo_mem.sv
// alu_fifo_mem
// Register-array storage for the ALU result buffer. It has one write port and
// one asynchronous read port. Reset clears every entry, so a buffer that has
// just come out of reset shows an all-zero head word.
//   clock, reset  rising-edge clock, asynchronous active-low reset
//   we, waddr, wdata  write port; the write takes effect on the clock edge
//   raddr, rdata      combinational read port
module alu_fifo_mem #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
// Buffers ALU result words and their status flags in a small FIFO, so the ALU
// can keep issuing while the consumer stalls. It also keeps a saturating
// count of accepted overflow results for debug readback.
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   producer handshake; in_ready is high while not full
//   in_result, in_*     result word and overflow/negative/zero flags
//   out_valid/out_ready consumer handshake; out_valid is high while not empty
//   out_result, out_*   head entry; it is a combinational read of storage
//   count               current occupancy
//   clear_stats         synchronous clear of ovf_events
//   ovf_events          saturating count of pushes with in_overflow set
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int LENGTH_v = ALU_LENGTH,
  parameter int DEPTH    = 4,
  parameter int STAT_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [2*LENGTH_v-1:0]      in_result,
  input  logic                       in_overflow,
  input  logic                       in_negative,
  input  logic                       in_zero,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [2*LENGTH_v-1:0]      out_result,
  output logic                       out_overflow,
  output logic                       out_negative,
  output logic                       out_zero,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       clear_stats,
  output logic [STAT_W-1:0]          ovf_events
);

  localparam int RES_W   = 2 * LENGTH_v;
  localparam int ENTRY_W = RES_W + ALU_FLAGS_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [STAT_W-1:0] OVF_MAX    = '1;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  alu_flags_t         wr_flags;
  alu_flags_t         head_flags;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  // The handshakes decode only the registered occupancy. This keeps
  // in_valid and out_ready off the ready/valid paths. A full buffer refuses
  // input even when a pop happens in the same cycle.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_flags = '{overflow: in_overflow, negative: in_negative, zero: in_zero};
  assign wr_entry = {in_result, wr_flags};

  alu_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  assign {out_result, head_flags} = head_entry;
  assign out_overflow = head_flags.overflow;
  assign out_negative = head_flags.negative;
  assign out_zero     = head_flags.zero;

  // The pointers wrap naturally because DEPTH is a power of two. The separate
  // count register tells full from empty when the pointers are equal.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear takes priority over a coincident overflow push. The counter sticks
  // at its maximum value instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_events <= '0;
    end else if (clear_stats) begin
      ovf_events <= '0;
    end else if (push && in_overflow && (ovf_events != OVF_MAX)) begin
      ovf_events <= ovf_events + STAT_W'(1);
    end
  end

endmodule
